// File: rtl/grey_counter.sv
// grey_counter: binary counter with a registered Grey-code mirror and a
// one-cycle wrap pulse. Load and synchronous reset are supported.
// Optional feature: define GREY_COUNTER_DECREMENT_EN to add a decrement
// port (up/down counting); without it the counter is up-only.
module grey_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
`ifdef GREY_COUNTER_DECREMENT_EN
  input  logic             decrement,
`endif
  input  logic             load_enable,
  input  logic [WIDTH-1:0] load_binary,
  output logic [WIDTH-1:0] count_binary,
  output logic [WIDTH-1:0] count_grey,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] next_binary;
  logic [WIDTH-1:0] next_grey;
  logic             next_wrapped;

  // Next-state selection: load beats counting; wrap only on a counting step.
  always_comb begin
    next_binary  = count_binary;
    next_wrapped = 1'b0;
    if (load_enable) begin
      next_binary = load_binary;
    end else begin
`ifdef GREY_COUNTER_DECREMENT_EN
      // Simultaneous up and down cancel out and hold the count.
      if (increment && !decrement) begin
        next_binary  = count_binary + ONE;
        next_wrapped = (count_binary == ALL_ONES);
      end else if (decrement && !increment) begin
        next_binary  = count_binary - ONE;
        next_wrapped = (count_binary == ZERO);
      end
`else
      if (increment) begin
        next_binary  = count_binary + ONE;
        next_wrapped = (count_binary == ALL_ONES);
      end
`endif
    end
    // Encoding before the register keeps count_grey a pure flop output.
    next_grey = next_binary ^ (next_binary >> 1);
  end

  // State register; reset overrides everything, discarding any pending step.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_binary <= ZERO;
      count_grey   <= ZERO;
      wrapped      <= 1'b0;
    end else begin
      count_binary <= next_binary;
      count_grey   <= next_grey;
      wrapped      <= next_wrapped;
    end
  end

endmodule

// File: tb/tb_grey_counter.sv
// Self-checking bench for grey_counter (WIDTH=4): directed cases plus random
// stimulus against a behavioural model. Honours GREY_COUNTER_DECREMENT_EN.
module tb_grey_counter;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clock = 1'b0;
  logic         reset, increment, load_enable, decrement;
  logic [W-1:0] load_binary;
  logic [W-1:0] count_binary, count_grey;
  logic         wrapped;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int m_bin;
  int m_wrap;
  int gtab [M];
  int prev_grey;

  always #5 clock = ~clock;

  grey_counter #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .increment    (increment),
`ifdef GREY_COUNTER_DECREMENT_EN
    .decrement    (decrement),
`endif
    .load_enable  (load_enable),
    .load_binary  (load_binary),
    .count_binary (count_binary),
    .count_grey   (count_grey),
    .wrapped      (wrapped)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: model advances from the held inputs, then all outputs compared.
  task automatic tick(input string tag);
    int  old;
    bit  up, dn, pure_up;
    old = m_bin;
    up  = increment;
`ifdef GREY_COUNTER_DECREMENT_EN
    dn  = decrement;
`else
    dn  = 1'b0;
`endif
    pure_up = 1'b0;
    @(posedge clock);
    #1;
    m_wrap = 0;
    if (reset) m_bin = 0;
    else if (load_enable) m_bin = int'(load_binary);
    else if (up && !dn) begin
      m_bin = (old + 1) % M;
      m_wrap = (old == M - 1);
      pure_up = 1'b1;
    end else if (dn && !up) begin
      m_bin = (old + M - 1) % M;
      m_wrap = (old == 0);
    end
    chk({tag, ".bin"},  int'(count_binary), m_bin);
    chk({tag, ".grey"}, int'(count_grey), gtab[m_bin]);
    chk({tag, ".wrap"}, int'(wrapped), m_wrap);
    if (pure_up)
      chk({tag, ".hamming"}, $countones(int'(count_grey) ^ prev_grey), 1);
    prev_grey = int'(count_grey);
  endtask

  task automatic drive(input bit r, input bit inc, input bit dec, input bit ld,
                       input int lv);
    reset       = r;
    increment   = inc;
    decrement   = dec;
    load_enable = ld;
    load_binary = W'(lv);
  endtask

  initial begin
    int seq [17] = '{0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0};

    // Reflected Grey code built by mirroring, independent of the XOR form.
    gtab[0] = 0;
    for (int k = 0; k < W; k++)
      for (int i = 0; i < (1 << k); i++)
        gtab[(1 << k) + i] = (1 << k) | gtab[(1 << k) - 1 - i];

    m_bin = 0; m_wrap = 0; prev_grey = 0;
    drive(1, 0, 0, 0, 0);
    tick("reset");

    // Full up-count cycle with the literal Grey sequence.
    drive(0, 1, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      tick("seq");
      chk("seq.table", int'(count_grey), seq[i]);
      chk("seq.wrap_only_at_0", int'(wrapped), (i == 16) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0);
    tick("hold");
    chk("hold.no_wrap", int'(wrapped), 0);

    // Load 0xA with increment also high.
    drive(0, 1, 0, 1, 'hA);
    tick("loadA");
    chk("loadA.bin",  int'(count_binary), 'hA);
    chk("loadA.grey", int'(count_grey), 'hF);
    chk("loadA.wrap", int'(wrapped), 0);

    // Load 0 from 0xF: no wrap pulse.
    drive(0, 0, 0, 1, 'hF);
    tick("loadF");
    drive(0, 0, 0, 1, 0);
    tick("load0");
    chk("load0.bin",  int'(count_binary), 0);
    chk("load0.wrap", int'(wrapped), 0);

    // Reset mid-count with competing increment/load, then resume.
    drive(0, 0, 0, 1, 7);
    tick("load7");
    drive(1, 1, 0, 1, 'h5);
    tick("rst_mid");
    chk("rst_mid.bin",  int'(count_binary), 0);
    chk("rst_mid.grey", int'(count_grey), 0);
    chk("rst_mid.wrap", int'(wrapped), 0);
    drive(0, 1, 0, 0, 0);
    tick("resume");
    chk("resume.bin", int'(count_binary), 1);

`ifdef GREY_COUNTER_DECREMENT_EN
    drive(1, 0, 0, 0, 0);
    tick("dec_rst");
    drive(0, 0, 1, 0, 0);
    tick("dec0");
    chk("dec0.bin",  int'(count_binary), 'hF);
    chk("dec0.grey", int'(count_grey), 'h8);
    chk("dec0.wrap", int'(wrapped), 1);
    drive(0, 1, 1, 0, 0);
    tick("updn");
    chk("updn.bin",  int'(count_binary), 'hF);
    chk("updn.wrap", int'(wrapped), 0);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) == 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, M - 1)));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
